// File: rtl/rsfq_drv_pkg.sv
// rtl/rsfq_drv_pkg.sv - shared types, timing helpers and parameter checks for the SFQ cell driver
package rsfq_drv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_SETUP,
    S_CLKP,
    S_HOLD
  } drv_state_e;

  // Cycles from a raw sfq_q toggle to its detected event being counted.
  localparam int SYNC_LAT = 3;

  function automatic int slot_period(input int data_gap, input int clk_gap);
    return 2 + data_gap + clk_gap;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic bit drv_params_ok(input int width, input int data_gap, input int clk_gap);
    return (width >= 1) && (data_gap >= 1) && (clk_gap >= SYNC_LAT);
  endfunction

endpackage

// File: rtl/rsfq_toggle_sync.sv
// rtl/rsfq_toggle_sync.sv - two-flop synchronizer plus edge detector for a toggle-encoded line
module rsfq_toggle_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 ^ s3;

endmodule

// File: rtl/rsfq_clocked_cell_driver.sv
// rtl/rsfq_clocked_cell_driver.sv - serializes a word into data/cell-clock toggles and captures the cell response
module rsfq_clocked_cell_driver
  import rsfq_drv_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DATA_GAP = 2,
  parameter int CLK_GAP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sfq_a,
  output logic             sfq_clk,
  input  logic             sfq_q,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_err
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int SW = $clog2(max_int(DATA_GAP, CLK_GAP) + 1);
  localparam logic [SW-1:0] DG_LAST   = SW'(DATA_GAP);
  localparam logic [SW-1:0] CG_LAST   = SW'(CLK_GAP);
  localparam logic [SW-1:0] WIN_FIRST = SW'(SYNC_LAT);

  if (!drv_params_ok(WIDTH, DATA_GAP, CLK_GAP)) begin : g_bad_params
    $error("rsfq_clocked_cell_driver: WIDTH>=1, DATA_GAP>=1 and CLK_GAP>=3 are needed");
  end

  drv_state_e       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] resp;
  logic [BW-1:0]    bits_left;
  logic [SW-1:0]    slot_cnt;
  logic [1:0]       win_cnt;
  logic             err_stray;
  logic             err_multi;

  logic             q_event;
  logic             window_open;
  logic             stray_now;
  logic [1:0]       win_next;
  logic             win_bit;
  logic [WIDTH-1:0] resp_shifted;

  rsfq_toggle_sync u_q_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sfq_q),
    .pulse (q_event)
  );

  // The window is judged on detected events, so it opens SYNC_LAT cycles after
  // the cell-clock toggle and closes on the final HOLD edge.
  always_comb begin
    window_open = (state == S_HOLD) && (slot_cnt >= WIN_FIRST);
    stray_now   = q_event && !window_open;
    win_next    = win_cnt;
    if (q_event && window_open && (win_cnt != 2'd2)) begin
      win_next = win_cnt + 2'd1;
    end
    win_bit      = (win_next != 2'd0);
    resp_shifted = WIDTH'({win_bit, resp} >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      sfq_a     <= 1'b0;
      sfq_clk   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 2'b00;
      shreg     <= '0;
      resp      <= '0;
      bits_left <= '0;
      slot_cnt  <= '0;
      win_cnt   <= 2'd0;
      err_stray <= 1'b0;
      err_multi <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      win_cnt   <= win_next;
      // Strays seen while idle stay pending and are reported with the next word.
      if (stray_now) begin
        err_stray <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            shreg     <= in_data;
            bits_left <= BW'(WIDTH);
            resp      <= '0;
            err_multi <= 1'b0;
            out_data  <= '0;
            out_err   <= 2'b00;
            in_ready  <= 1'b0;
            state     <= S_DATA;
          end
        end

        S_DATA: begin
          if (bits_left == '0) begin
            out_valid <= 1'b1;
            out_data  <= resp;
            out_err   <= {err_multi, err_stray | stray_now};
            err_stray <= 1'b0;
            err_multi <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end else begin
            if (shreg[0]) begin
              sfq_a <= ~sfq_a;
            end
            slot_cnt <= SW'(1);
            state    <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (slot_cnt == DG_LAST) begin
            state <= S_CLKP;
          end else begin
            slot_cnt <= slot_cnt + SW'(1);
          end
        end

        S_CLKP: begin
          sfq_clk  <= ~sfq_clk;
          slot_cnt <= SW'(1);
          state    <= S_HOLD;
        end

        S_HOLD: begin
          if (slot_cnt == CG_LAST) begin
            resp      <= resp_shifted;
            if (win_next == 2'd2) begin
              err_multi <= 1'b1;
            end
            win_cnt   <= 2'd0;
            shreg     <= shreg >> 1;
            bits_left <= bits_left - BW'(1);
            state     <= S_DATA;
          end else begin
            slot_cnt <= slot_cnt + SW'(1);
          end
        end

        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsfq_clocked_cell_driver.sv
// tb/tb_rsfq_clocked_cell_driver.sv - directed bench with a clocked-NOT loopback model
module tb_rsfq_clocked_cell_driver;

  localparam int W  = 4;
  localparam int DG = 2;
  localparam int CG = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         sfq_a;
  logic         sfq_clk;
  logic         sfq_q = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_err;

  int passes = 0;
  int total  = 0;
  int cyc    = 0;
  int e0     = 0;
  int e0_first;
  int ov_cnt;
  bit seen;
  logic exp_r, exp_v, exp_a, exp_c;

  logic loop_en = 1'b0;
  logic a_prev = 1'b0, c_prev = 1'b0, a_flag = 1'b0, pend = 1'b0;

  rsfq_clocked_cell_driver #(.WIDTH(W), .DATA_GAP(DG), .CLK_GAP(CG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sfq_a     (sfq_a),
    .sfq_clk   (sfq_clk),
    .sfq_q     (sfq_q),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Clocked NOT: output toggles one cycle after a cell-clock toggle with no data toggle since the last one.
  always @(posedge clk) begin
    #1;
    if (pend) begin
      sfq_q = ~sfq_q;
      pend  = 1'b0;
    end
    if (sfq_a !== a_prev) a_flag = 1'b1;
    if (sfq_clk !== c_prev) begin
      if (loop_en && !a_flag) pend = 1'b1;
      a_flag = 1'b0;
    end
    a_prev = sfq_a;
    c_prev = sfq_clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    loop_en = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sfq_q = 1'b0;
    pend  = 1'b0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    a_flag = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string tag, input logic [W-1:0] d);
    chk({tag, "_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    e0       = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_ov(input string tag, input logic [W-1:0] exp_d, input logic [1:0] exp_e);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk({tag, "_seen"}, seen, 1);
    chk({tag, "_lat"}, cyc - e0, 33);
    chk({tag, "_data"}, out_data, exp_d);
    chk({tag, "_err"}, out_err, exp_e);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {in_ready, out_valid, sfq_a, sfq_clk, out_data, out_err}, 10'b10_0000_0000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Word 1011 with cycle-by-cycle line timing
    loop_en = 1'b1;
    send("t1", 4'b1011);
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk);
      #1;
      exp_a = ((k >= 1) && (k < 9)) || (k >= 25);
      exp_c = ((k >= 4) && (k < 12)) || ((k >= 20) && (k < 28));
      exp_r = (k >= 33);
      exp_v = (k == 33);
      chk($sformatf("t1_lines_k%0d", k), {in_ready, out_valid, sfq_a, sfq_clk}, {exp_r, exp_v, exp_a, exp_c});
      if (k == 33) begin
        chk("t1_data", out_data, 4'b0100);
        chk("t1_err", out_err, 2'b00);
      end
      if (k == 34) chk("t1_data_hold", out_data, 4'b0100);
    end

    // Back-to-back 0000 then 1111 with in_valid held
    do_reset();
    loop_en  = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'b0000;
    @(posedge clk);
    #1;
    e0       = cyc;
    e0_first = cyc;
    in_data  = 4'b1111;
    wait_ov("b2b_w0", 4'b1111, 2'b00);
    @(posedge clk);
    #1;
    chk("b2b_accept", in_ready, 0);
    e0       = cyc;
    in_valid = 1'b0;
    chk("b2b_spacing", e0 - e0_first, 34);
    wait_ov("b2b_w1", 4'b0000, 2'b00);

    // Double toggle inside the slot-2 capture window
    do_reset();
    loop_en = 1'b0;
    send("dbl", 4'b0000);
    repeat (20) @(posedge clk);
    #1;
    sfq_q = ~sfq_q;
    @(posedge clk);
    #1;
    sfq_q = ~sfq_q;
    wait_ov("dbl", 4'b0100, 2'b10);

    // Stray toggle while idle is reported with the next word
    do_reset();
    loop_en = 1'b1;
    sfq_q   = ~sfq_q;
    repeat (5) @(posedge clk);
    #1;
    send("stray", 4'b1111);
    wait_ov("stray", 4'b0000, 2'b01);

    // Reset in the middle of a word
    do_reset();
    loop_en = 1'b1;
    send("rst", 4'b1011);
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_outputs", {in_ready, out_valid, sfq_a, sfq_clk, out_data, out_err}, 10'b10_0000_0000);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    ov_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) ov_cnt++;
    end
    chk("rst_no_valid", ov_cnt, 0);
    send("rst_next", 4'b1011);
    wait_ov("rst_next", 4'b0100, 2'b00);

    // in_data changes while busy: only the accepted value counts
    do_reset();
    loop_en  = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'b0011;
    @(posedge clk);
    #1;
    e0   = cyc;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      in_data = 4'($urandom);
      @(posedge clk);
      #1;
      if (out_valid) begin
        seen     = 1'b1;
        in_valid = 1'b0;
      end
    end
    chk("held_seen", seen, 1);
    chk("held_lat", cyc - e0, 33);
    chk("held_data", out_data, 4'b1100);
    chk("held_err", out_err, 2'b00);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
